// File: rtl/pll_lock_sequencer_if.sv
// Sequencer-facing signal bundle: PLL lock in, PLL reset and system reset out.
// master = sequencer side, slave = board / consumer side.
interface pll_lock_sequencer_if;
    logic       lock;
    logic       force_relock;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       ready;
    logic [7:0] lost_cnt;
    logic [7:0] timeout_cnt;
    logic [2:0] state;

    modport master (
        input  lock,
        input  force_relock,
        output pll_reset,
        output sys_rst_n,
        output ready,
        output lost_cnt,
        output timeout_cnt,
        output state
    );

    modport slave (
        output lock,
        output force_relock,
        input  pll_reset,
        input  sys_rst_n,
        input  ready,
        input  lost_cnt,
        input  timeout_cnt,
        input  state
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// rPLL reset pulse, lock wait with timeout/retry, lock qualification and
// clean system reset release; runs on the free-running board clock.
module pll_lock_sequencer #(
    parameter int PLL_RST_CYCLES = 27,
    parameter int LOCK_TIMEOUT   = 270000,
    parameter int LOCK_STABLE    = 2700,
    parameter int RESET_HOLD     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pll_lock_sequencer_if.master  bus
);

    localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B = (LOCK_STABLE > RESET_HOLD) ? LOCK_STABLE : RESET_HOLD;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_P + 1);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t RST_LAST = cnt_t'(PLL_RST_CYCLES - 1);
    localparam cnt_t TMO_LAST = cnt_t'(LOCK_TIMEOUT - 1);
    localparam cnt_t STB_LAST = cnt_t'(LOCK_STABLE - 1);
    localparam cnt_t HLD_LAST = cnt_t'(RESET_HOLD - 1);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        HOLD      = 3'd3,
        RUN       = 3'd4
    } state_e;

    state_e     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [7:0] lost_q, lost_d;
    logic [7:0] tmo_q, tmo_d;
    logic       sync1_q;
    logic       lock_s_q;
    logic       pll_reset_q;
    logic       sys_rst_n_q;
    logic       ready_q;

    always_comb begin
        state_d = state_q;
        lost_d  = lost_q;
        tmo_d   = tmo_q;
        // force_relock outranks any lock-driven or counter-driven move
        if (bus.force_relock && state_q != PLL_RST) begin
            state_d = PLL_RST;
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (lock_s_q) begin
                        state_d = STABLE;
                    end else if (cnt_q == TMO_LAST) begin
                        state_d = PLL_RST;
                        if (tmo_q != 8'hFF) tmo_d = tmo_q + 8'd1;
                    end
                end
                STABLE: begin
                    if (!lock_s_q)             state_d = WAIT_LOCK;
                    else if (cnt_q == STB_LAST) state_d = HOLD;
                end
                HOLD: begin
                    if (!lock_s_q)             state_d = WAIT_LOCK;
                    else if (cnt_q == HLD_LAST) state_d = RUN;
                end
                RUN: begin
                    if (!lock_s_q) begin
                        state_d = WAIT_LOCK;
                        if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
                    end
                end
                default: state_d = PLL_RST;
            endcase
        end
        cnt_d = (state_d != state_q) ? '0 : cnt_q + cnt_t'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            lost_q      <= '0;
            tmo_q       <= '0;
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lost_q      <= lost_d;
            tmo_q       <= tmo_d;
            sync1_q     <= bus.lock;
            lock_s_q    <= sync1_q;
            pll_reset_q <= (state_d == PLL_RST);
            sys_rst_n_q <= (state_d == RUN);
            ready_q     <= (state_d == RUN);
        end
    end

    assign bus.pll_reset   = pll_reset_q;
    assign bus.sys_rst_n   = sys_rst_n_q;
    assign bus.ready       = ready_q;
    assign bus.lost_cnt    = lost_q;
    assign bus.timeout_cnt = tmo_q;
    assign bus.state       = state_q;

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Consumes the `lock` output of the board rPLL and drives its `RESET` input. The block generates the PLL reset pulse, waits for lock with a timeout and automatic retry, and qualifies lock for a stable interval. It then releases a clean, registered system reset to the cartridge logic. It runs on the free-running 27 MHz board clock, not on any PLL output, so it keeps operating while the PLL is unlocked. It also counts lock losses and lock timeouts for debug.

## Interface
- `PLL_RST_CYCLES`, 27: clk cycles that `pll_reset` is held high per PLL reset entry (1 µs).
- `LOCK_TIMEOUT`, 270000: clk cycles spent in WAIT_LOCK without lock before retrying the PLL reset (10 ms).
- `LOCK_STABLE`, 2700: consecutive clk cycles synchronized lock must stay high before reset release proceeds (100 µs).
- `RESET_HOLD`, 16: extra clk cycles `sys_rst_n` stays low after lock is qualified.
- `clk` in 1: 27 MHz board clock, the sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `lock` in 1: rPLL LOCK, asynchronous to `clk`.
- `force_relock` in 1: synchronous single-cycle request to restart the PLL.
- `pll_reset` out 1: drives rPLL RESET, active high.
- `sys_rst_n` out 1: active-low reset for downstream logic.
- `ready` out 1: high only in RUN.
- `lost_cnt` out 8: count of lock losses while in RUN; saturates at 255.
- `timeout_cnt` out 8: count of LOCK_TIMEOUT expiries; saturates at 255.
- `state` out 3: encoded state for debug. PLL_RST=0, WAIT_LOCK=1, STABLE=2, HOLD=3, RUN=4.

## Operation
- **Lock synchronizer:** `lock` passes through two flops to form `lock_s`. No other path uses `lock` directly.
- **Cycle counter:** one shared counter, sized to the largest parameter. It clears on every state entry.
- **PLL_RST:**
  - `pll_reset`=1.
  - After `PLL_RST_CYCLES` cycles, go to WAIT_LOCK.
- **WAIT_LOCK:**
  - If `lock_s`=1, go to STABLE.
  - Otherwise, if the counter reaches `LOCK_TIMEOUT`, go to PLL_RST and increment `timeout_cnt`.
- **STABLE:**
  - If `lock_s`=0, go to WAIT_LOCK. The counter clears, so the timeout restarts.
  - After `LOCK_STABLE` cycles with `lock_s`=1, go to HOLD.
- **HOLD:**
  - If `lock_s`=0, go to WAIT_LOCK.
  - After `RESET_HOLD` cycles, go to RUN.
- **RUN:**
  - `sys_rst_n`=1 and `ready`=1.
  - If `lock_s`=0, go to WAIT_LOCK and increment `lost_cnt`. The PLL is not reset here; only a timeout or `force_relock` resets it.
- **force_relock:** from any state other than PLL_RST, go to PLL_RST. While already in PLL_RST it is ignored; the pulse does not extend.
- **Priority on simultaneous events:** `force_relock` > lock drop > timeout or interval expiry.
- **Counter saturation:** both counters hold at 255 and do not wrap.
- **Registered outputs:** every output is registered and decoded from next-state. Each output therefore changes on the same edge as `state`.

## Timing
- **Reset values** (while `rst_n`=0): state=PLL_RST, `pll_reset`=1, `sys_rst_n`=0, `ready`=0, `lost_cnt`=0, `timeout_cnt`=0, synchronizer flops=0, counter=0.
- **Behaviour after reset release:** `pll_reset` stays high for exactly `PLL_RST_CYCLES` edges, then falls.
- **Edge numbering:** edge 1 is the first edge at which `lock` is sampled high.
  - `lock_s` is high after edge 2.
  - STABLE is entered at edge 3.
  - `sys_rst_n` and `ready` rise at edge 3+`LOCK_STABLE`+`RESET_HOLD`.
- **Lock loss in RUN:** `sys_rst_n` and `ready` fall at the 3rd edge after the first edge that samples `lock` low. `lost_cnt` increments on that same edge.
- **force_relock:** the edge sampling it moves the state to PLL_RST. `pll_reset` rises and `sys_rst_n` falls on that edge.
- **Glitch rejection:**
  - A `lock` glitch shorter than one clk period may be missed entirely; this is acceptable.
  - Any `lock_s` low during STABLE or HOLD restarts qualification.
- **Asynchronous reset mid-operation:** `sys_rst_n` goes low immediately, with no clk required. All state returns to reset values.

## Test plan
Bench parameters: `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT`=20, `LOCK_STABLE`=8, `RESET_HOLD`=3.

- **Nominal bring-up:** release `rst_n`; raise `lock` 10 cycles later → `pll_reset` high for exactly 4 edges; `sys_rst_n` and `ready` rise 14 edges after `lock` is first sampled high; `state`=4.
- **Timeout retry:** hold `lock`=0 → `pll_reset` pulses 4 cycles every 24 cycles; `timeout_cnt` increments by 1 at each pulse. Then raise `lock` → normal release.
- **Qualification restart:** drop `lock` for 2 cycles 5 cycles into STABLE → state returns to WAIT_LOCK. After a stable `lock`, release occurs 14 edges after the re-rise, and `timeout_cnt` is unchanged.
- **Loss in RUN:** drop `lock` → `sys_rst_n` falls at the 3rd edge and `lost_cnt`=1. Repeat 300 times → `lost_cnt` saturates at 255.
- **force_relock in RUN, with a simultaneous lock drop:** `state`→0, `pll_reset`=1, and `lost_cnt` unchanged.
- **Async reset mid-HOLD:** assert `rst_n`=0 between edges → `sys_rst_n` stays 0, `pll_reset`=1 immediately, and both counters read 0.
